bram_read_arbiter: RTL and testbench

- Shares one block-RAM read port among NUM_REQ reader modules.
- Each reader presents a request/address pair every cycle it wants a word. The arbiter grants one requester per cycle using round-robin with a bounded burst.
- It drives the BRAM port, tracks in-flight reads in a tag pipeline, and routes returning data back to the owner as that reader's valid/data input.
- It sits between the reader modules and the BRAM, replacing their direct BRAM connection.

---
 rtl/bram_read_arbiter.sv | 152 +++++++++++++++
 tb/tb_bram_read_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_read_arbiter.sv
// ---------------------------------------------------------------------------
// bram_read_arbiter
//
// Shares one block-RAM read port among NUM_REQ readers. One requester is
// granted per cycle (round-robin with a bounded burst), the granted address is
// registered onto the BRAM port, and a tag pipeline tracks the owner of every
// in-flight read so the returning word is flagged to the right reader.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   req        per-requester read request
//   addr_in    packed addresses, requester i at [i*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS]
//   grant      one-hot, combinational: requester's read accepted this cycle
//   bram_en    BRAM read enable (registered)
//   bram_addr  BRAM read address (registered, holds when idle)
//   bram_data  BRAM read data, valid BRAM_LATENCY cycles after bram_en
//   valid_out  one-hot: returned word belongs to requester i
//   data_out   returned word, broadcast to all requesters
// ---------------------------------------------------------------------------
module bram_read_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int LOG_NUM_REQ     = 2,
  parameter int DATA_WIDTH      = 8,
  parameter int LOG_MAX_ADDRESS = 16,
  parameter int BRAM_LATENCY    = 1,
  parameter int MAX_BURST       = 4,
  parameter int LOG_MAX_BURST   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ*LOG_MAX_ADDRESS-1:0] addr_in,
  output logic [NUM_REQ-1:0]                 grant,
  output logic                               bram_en,
  output logic [LOG_MAX_ADDRESS-1:0]         bram_addr,
  input  logic [DATA_WIDTH-1:0]              bram_data,
  output logic [NUM_REQ-1:0]                 valid_out,
  output logic [DATA_WIDTH-1:0]              data_out
);

  localparam logic [LOG_NUM_REQ-1:0]   MAX_IDX   = LOG_NUM_REQ'(NUM_REQ - 1);
  localparam logic [LOG_MAX_BURST-1:0] BURST_MAX = LOG_MAX_BURST'(MAX_BURST);

  logic [LOG_NUM_REQ-1:0]     r_ptr;
  logic [LOG_NUM_REQ-1:0]     r_owner;
  logic [LOG_MAX_BURST-1:0]   r_burst_cnt;
  logic                       r_bram_en;
  logic [LOG_MAX_ADDRESS-1:0] r_bram_addr;
  logic [LOG_NUM_REQ-1:0]     r_issue_id;
  logic                       r_tag_vld [BRAM_LATENCY];
  logic [LOG_NUM_REQ-1:0]     r_tag_id  [BRAM_LATENCY];

  logic                       w_gnt_vld;
  logic [LOG_NUM_REQ-1:0]     w_gnt_id;
  logic [LOG_NUM_REQ-1:0]     w_search_idx;
  logic [LOG_NUM_REQ-1:0]     w_gnt_next_idx;
  logic [LOG_MAX_BURST-1:0]   w_next_cnt;
  logic [LOG_MAX_ADDRESS-1:0] w_gnt_addr;

  // Arbitration: burst continuation first, otherwise a circular search from
  // r_ptr. The wrap compares against NUM_REQ-1 so non-power-of-two NUM_REQ
  // never visits an invalid slot.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_gnt_vld    = 1'b0;
    w_gnt_id     = r_ptr;
    w_search_idx = r_ptr;
    if (!rst && (|req)) begin
      if (req[r_owner] && (r_burst_cnt != '0) && (r_burst_cnt < BURST_MAX)) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = r_owner;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!w_gnt_vld && req[w_search_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = w_search_idx;
          end
          w_search_idx = (w_search_idx == MAX_IDX) ? '0 : w_search_idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant      = '0;
    w_gnt_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_id == LOG_NUM_REQ'(i)) begin
        grant[i]   = w_gnt_vld;
        w_gnt_addr = addr_in[i*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS];
      end
    end
  end

  // A repeat grant to the current owner extends its burst; anything else
  // starts a fresh burst of one. Once the burst saturates, the pointer moves
  // past the owner so the others get their turn.
  assign w_next_cnt     = ((w_gnt_id == r_owner) && (r_burst_cnt < BURST_MAX))
                          ? r_burst_cnt + 1'b1 : LOG_MAX_BURST'(1);
  assign w_gnt_next_idx = (w_gnt_id == MAX_IDX) ? '0 : w_gnt_id + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_bram_en   <= 1'b0;
      r_bram_addr <= '0;
      r_issue_id  <= '0;
      for (int k = 0; k < BRAM_LATENCY; k++) r_tag_vld[k] <= 1'b0;
    end else begin
      r_bram_en <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_owner     <= w_gnt_id;
        r_burst_cnt <= w_next_cnt;
        r_ptr       <= (w_next_cnt == BURST_MAX) ? w_gnt_next_idx : w_gnt_id;
        r_bram_addr <= w_gnt_addr;
        r_issue_id  <= w_gnt_id;
      end else begin
        r_burst_cnt <= '0;
      end
      // Stage 0 captures the read presented to the BRAM this cycle, so the
      // last stage lines up with the BRAM output BRAM_LATENCY cycles later.
      r_tag_vld[0] <= r_bram_en;
      for (int k = 1; k < BRAM_LATENCY; k++) r_tag_vld[k] <= r_tag_vld[k-1];
    end
  end

  // NOTE: the tag ids are qualified by their valid bits, so only the valid
  // bits need a reset; the id shift register is left unreset on purpose.
  always_ff @(posedge clk) begin
    r_tag_id[0] <= r_issue_id;
    for (int k = 1; k < BRAM_LATENCY; k++) r_tag_id[k] <= r_tag_id[k-1];
  end

  assign bram_en   = r_bram_en;
  assign bram_addr = r_bram_addr;
  assign data_out  = bram_data;

  always_comb begin
    valid_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_out[i] = r_tag_vld[BRAM_LATENCY-1] &&
                     (r_tag_id[BRAM_LATENCY-1] == LOG_NUM_REQ'(i));
    end
  end

endmodule

// File: tb/tb_bram_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_read_arbiter
//
// Three arbiter instances share the same request stimulus:
//   u_dut_a  : MAX_BURST=4, BRAM_LATENCY=1
//   u_dut_rr : MAX_BURST=1, BRAM_LATENCY=1 (pure round-robin)
//   u_dut_l3 : MAX_BURST=4, BRAM_LATENCY=3
// Each has its own BRAM model returning bram_word(addr) after its latency.
// ---------------------------------------------------------------------------
module tb_bram_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] addr_in;

  logic [3:0]  g_a,  vo_a,  g_rr, vo_rr, g_l3, vo_l3;
  logic        en_a, en_rr, en_l3;
  logic [15:0] ad_a, ad_rr, ad_l3;
  logic [7:0]  bd_a, bd_rr, bd_l3, do_a, do_rr, do_l3;
  logic [7:0]  p0_l3, p1_l3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] bram_word(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always_ff @(posedge clk) begin
    bd_a  <= bram_word(ad_a);
    bd_rr <= bram_word(ad_rr);
    p0_l3 <= bram_word(ad_l3);
    p1_l3 <= p0_l3;
    bd_l3 <= p1_l3;
  end

  bram_read_arbiter #(.MAX_BURST(4), .BRAM_LATENCY(1)) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .grant(g_a),
    .bram_en(en_a), .bram_addr(ad_a), .bram_data(bd_a),
    .valid_out(vo_a), .data_out(do_a));

  bram_read_arbiter #(.MAX_BURST(1), .BRAM_LATENCY(1)) u_dut_rr (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .grant(g_rr),
    .bram_en(en_rr), .bram_addr(ad_rr), .bram_data(bd_rr),
    .valid_out(vo_rr), .data_out(do_rr));

  bram_read_arbiter #(.MAX_BURST(4), .BRAM_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .grant(g_l3),
    .bram_en(en_l3), .bram_addr(ad_l3), .bram_data(bd_l3),
    .valid_out(vo_l3), .data_out(do_l3));

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 2 units later, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [15:0] a);
    addr_in[i*16 +: 16] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    req     = 4'b1111;
    addr_in = '0;
    tick();
    for (int c = 0; c < 3; c++) begin
      #2;
      n_tests++;
      if ({g_a, g_rr, g_l3} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_grant cyc=%0d got a=%b rr=%b l3=%b want 0000", c, g_a, g_rr, g_l3);
      end
      n_tests++;
      if ({en_a, en_rr, en_l3} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_bram_en cyc=%0d got %b want 000", c, {en_a, en_rr, en_l3});
      end
      n_tests++;
      if ({vo_a, vo_rr, vo_l3} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_valid cyc=%0d got a=%b rr=%b l3=%b want 0000", c, vo_a, vo_rr, vo_l3);
      end
      tick();
    end
    rst = 1'b0;
    #2;
    n_tests++;
    if ({g_a, g_rr, g_l3} !== {3{4'b0001}}) begin
      n_fail++;
      $display("FAIL first_grant got a=%b rr=%b l3=%b want 0001", g_a, g_rr, g_l3);
    end
    tick();
  endtask

  task automatic test_single();
    logic [15:0] a;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      req = (c < 10) ? 4'b0100 : 4'b0000;
      set_addr(2, 16'h0010 + 16'(c));
      #2;
      n_tests++;
      if (g_a !== ((c < 10) ? 4'b0100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL single_grant cyc=%0d got %b want %b", c, g_a, (c < 10) ? 4'b0100 : 4'b0000);
      end
      if (c >= 1 && c <= 10) begin
        a = 16'h0010 + 16'(c - 1);
        n_tests++;
        if (en_a !== 1'b1 || ad_a !== a) begin
          n_fail++;
          $display("FAIL single_issue cyc=%0d got en=%b addr=%h want en=1 addr=%h", c, en_a, ad_a, a);
        end
      end else if (c == 0 || c == 11) begin
        n_tests++;
        if (en_a !== 1'b0) begin
          n_fail++;
          $display("FAIL single_idle_en cyc=%0d got %b want 0", c, en_a);
        end
      end
      if (c >= 2 && c <= 11) begin
        a = 16'h0010 + 16'(c - 2);
        n_tests++;
        if (vo_a !== 4'b0100 || do_a !== bram_word(a)) begin
          n_fail++;
          $display("FAIL single_return cyc=%0d got valid=%b data=%h want valid=0100 data=%h",
                   c, vo_a, do_a, bram_word(a));
        end
      end else begin
        n_tests++;
        if (vo_a !== 4'b0000) begin
          n_fail++;
          $display("FAIL single_no_return cyc=%0d got %b want 0000", c, vo_a);
        end
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_a, exp_rr;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      req = 4'b1111;
      #2;
      exp_a  = 4'b0001 << (c / 4);
      exp_rr = 4'b0001 << (c % 4);
      n_tests++;
      if (g_a !== exp_a) begin
        n_fail++;
        $display("FAIL fair_burst4 cyc=%0d got %b want %b", c, g_a, exp_a);
      end
      n_tests++;
      if (g_rr !== exp_rr) begin
        n_fail++;
        $display("FAIL fair_burst1 cyc=%0d got %b want %b", c, g_rr, exp_rr);
      end
      tick();
    end
  endtask

  task automatic test_burst_break();
    logic [3:0] req_v [7];
    logic [3:0] exp_v [7];
    req_v = '{4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
    exp_v = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req = req_v[c];
      #2;
      n_tests++;
      if (g_a !== exp_v[c]) begin
        n_fail++;
        $display("FAIL burst_break cyc=%0d got %b want %b", c, g_a, exp_v[c]);
      end
      tick();
    end
  endtask

  task automatic test_latency();
    logic [15:0] a;
    logic [3:0]  exp_g;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      exp_g = (c >= 6) ? 4'b0000 : ((c % 2 == 0) ? 4'b0010 : 4'b1000);
      req   = exp_g;
      set_addr(1, 16'h0100 + 16'(c));
      set_addr(3, 16'h0300 + 16'(c));
      #2;
      n_tests++;
      if (g_l3 !== exp_g) begin
        n_fail++;
        $display("FAIL lat_grant cyc=%0d got %b want %b", c, g_l3, exp_g);
      end
      if (c >= 4 && c < 10) begin
        a = (((c - 4) % 2) == 0) ? 16'h0100 + 16'(c - 4) : 16'h0300 + 16'(c - 4);
        exp_g = (((c - 4) % 2) == 0) ? 4'b0010 : 4'b1000;
        n_tests++;
        if (vo_l3 !== exp_g || do_l3 !== bram_word(a)) begin
          n_fail++;
          $display("FAIL lat_return cyc=%0d got valid=%b data=%h want valid=%b data=%h",
                   c, vo_l3, do_l3, exp_g, bram_word(a));
        end
      end else begin
        n_tests++;
        if (vo_l3 !== 4'b0000) begin
          n_fail++;
          $display("FAIL lat_no_return cyc=%0d got %b want 0000", c, vo_l3);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req = 4'b0010;
    set_addr(1, 16'h0A11);
    #2;
    n_tests++;
    if (g_l3 !== 4'b0010) begin
      n_fail++;
      $display("FAIL midflight_g1 got %b want 0010", g_l3);
    end
    tick();
    req = 4'b1000;
    set_addr(3, 16'h0B33);
    #2;
    n_tests++;
    if (g_l3 !== 4'b1000) begin
      n_fail++;
      $display("FAIL midflight_g2 got %b want 1000", g_l3);
    end
    tick();
    rst = 1'b1;
    req = 4'b1010;
    #2;
    n_tests++;
    if (g_l3 !== 4'b0000) begin
      n_fail++;
      $display("FAIL midflight_grant_in_rst got %b want 0000", g_l3);
    end
    tick();
    rst = 1'b0;
    #2;
    n_tests++;
    if (g_l3 !== 4'b0010) begin
      n_fail++;
      $display("FAIL midflight_post_reset_grant got %b want 0010", g_l3);
    end
    tick();
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_tests++;
      if (vo_l3 !== 4'b0000) begin
        n_fail++;
        $display("FAIL midflight_discard cyc=%0d got %b want 0000", c, vo_l3);
      end
      tick();
    end
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'b0000;
    addr_in = '0;
    test_reset();
    test_single();
    test_fairness();
    test_burst_break();
    test_latency();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
